// File: rtl/fpu_wb_buffer.sv
// Writeback buffer for the fixed-latency FPU multiplier: tracks tags
// through a shadow pipe and queues {tag,result} for register writeback.
module fpu_wb_buffer #(
  parameter int LATENCY = 3,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 6,
  parameter int DATA_W  = 32
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     issue_en,
  input  logic [TAG_W-1:0]         issue_tag,
  output logic                     issue_ok,
  input  logic                     fu_ready,
  input  logic [DATA_W-1:0]        fu_result,
  output logic                     wb_valid,
  output logic [TAG_W-1:0]         wb_tag,
  output logic [DATA_W-1:0]        wb_data,
  input  logic                     wb_ack,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = CW + 1;
  localparam int IW = $clog2(LATENCY + 1);

  logic [LATENCY-1:0] v_q, v_d;
  logic [TAG_W-1:0]   tag_q [LATENCY];
  logic [TAG_W-1:0]   tag_d [LATENCY];
  logic [IW-1:0]      infl_q, infl_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [PW-1:0]      wp_q, wp_d;
  logic [PW-1:0]      rp_q, rp_d;
  logic [TAG_W-1:0]   mt_q [DEPTH];
  logic [TAG_W-1:0]   mt_d [DEPTH];
  logic [DATA_W-1:0]  md_q [DEPTH];
  logic [DATA_W-1:0]  md_d [DEPTH];
  logic               err_q, err_d;

  logic          last_v;
  logic          full;
  logic          pop;
  logic          push;
  logic [SW-1:0] occ;

  always_comb begin
    last_v   = v_q[LATENCY-1];
    occ      = {1'b0, cnt_q} + SW'(infl_q);
    issue_ok = occ < SW'(DEPTH);
    full     = cnt_q == CW'(DEPTH);
    pop      = (cnt_q != '0) & wb_ack;
    // a full FIFO still accepts a capture if the head leaves on the same edge
    push     = last_v & (~full | pop);

    v_d      = '0;
    tag_d    = tag_q;
    v_d[0]   = issue_en;
    tag_d[0] = issue_tag;
    for (int i = 1; i < LATENCY; i++) begin
      v_d[i]   = v_q[i-1];
      tag_d[i] = tag_q[i-1];
    end

    infl_d = infl_q + IW'(issue_en) - IW'(last_v);
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
    wp_d   = wp_q + PW'(push);
    rp_d   = rp_q + PW'(pop);

    mt_d = mt_q;
    md_d = md_q;
    if (push) begin
      mt_d[wp_q] = tag_q[LATENCY-1];
      md_d[wp_q] = fu_result;
    end

    err_d = err_q
          | (issue_en & ~issue_ok)
          | (last_v & ~fu_ready);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v_q    <= '0;
      infl_q <= '0;
      cnt_q  <= '0;
      wp_q   <= '0;
      rp_q   <= '0;
      err_q  <= 1'b0;
      for (int i = 0; i < LATENCY; i++) begin
        tag_q[i] <= '0;
      end
      for (int i = 0; i < DEPTH; i++) begin
        mt_q[i] <= '0;
        md_q[i] <= '0;
      end
    end else begin
      v_q    <= v_d;
      tag_q  <= tag_d;
      infl_q <= infl_d;
      cnt_q  <= cnt_d;
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      mt_q   <= mt_d;
      md_q   <= md_d;
      err_q  <= err_d;
    end
  end

  assign wb_valid = cnt_q != '0;
  assign wb_tag   = mt_q[rp_q];
  assign wb_data  = md_q[rp_q];
  assign count    = cnt_q;
  assign err      = err_q;

endmodule

// File: tb/tb_fpu_wb_buffer.sv
// Bench for fpu_wb_buffer: directed scenarios plus a random run
// compared against a queue-level model of the buffer.
module tb_fpu_wb_buffer;

  localparam int LAT = 3;
  localparam int DEP = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        issue_en = 1'b0;
  logic [5:0]  issue_tag = '0;
  logic        issue_ok;
  logic        fu_ready = 1'b0;
  logic [31:0] fu_result = '0;
  logic        wb_valid;
  logic [5:0]  wb_tag;
  logic [31:0] wb_data;
  logic        wb_ack = 1'b0;
  logic [2:0]  count;
  logic        err;

  fpu_wb_buffer dut (
    .clk(clk), .rstn(rstn),
    .issue_en(issue_en), .issue_tag(issue_tag),
    .issue_ok(issue_ok),
    .fu_ready(fu_ready), .fu_result(fu_result),
    .wb_valid(wb_valid), .wb_tag(wb_tag),
    .wb_data(wb_data), .wb_ack(wb_ack),
    .count(count), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        rdy;
  } sch_t;
  typedef struct {
    int         due;
    logic [5:0] tag;
  } pend_t;
  typedef struct {
    logic [5:0]  tag;
    logic [31:0] data;
  } ent_t;

  sch_t  sched[$];
  pend_t pend[$];
  ent_t  mq[$];
  logic  m_err = 1'b0;
  logic  nready = 1'b0;
  int    cyc = 0;
  int    errors = 0;
  int    checks = 0;

  // One clock: drive inputs, advance the model on the edge, return at negedge.
  task automatic tick(input logic en, input logic [5:0] tag,
                      input logic ack, input logic [31:0] data);
    bit   ok;
    bit   pop;
    bit   push;
    ent_t e;
    issue_en  = en;
    issue_tag = tag;
    wb_ack    = ack;
    fu_ready  = 1'($urandom);
    fu_result = $urandom;
    if (sched.size() != 0 && sched[0].due == cyc) begin
      fu_ready  = sched[0].rdy;
      fu_result = sched[0].data;
      void'(sched.pop_front());
    end
    if (en) sched.push_back('{cyc + LAT, data, !nready});
    @(posedge clk);
    if (!rstn) begin
      pend.delete();
      mq.delete();
      m_err = 1'b0;
    end else begin
      ok   = (mq.size() + pend.size()) < DEP;
      pop  = mq.size() != 0 && ack;
      push = 1'b0;
      e    = '{6'd0, 32'd0};
      if (en && !ok) m_err = 1'b1;
      if (pend.size() != 0 && pend[0].due == cyc) begin
        if (!fu_ready) m_err = 1'b1;
        push = mq.size() < DEP || pop;
        e    = '{pend[0].tag, fu_result};
        void'(pend.pop_front());
      end
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(e);
      if (en) pend.push_back('{cyc + LAT, tag});
    end
    cyc++;
    @(negedge clk);
    issue_en = 1'b0;
    wb_ack   = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (issue_ok !== 1'b1) begin
      errors++; $display("FAIL rst_issue_ok got=%b exp=1", issue_ok);
    end
    checks++;
    if (wb_valid !== 1'b0) begin
      errors++; $display("FAIL rst_wb_valid got=%b exp=0", wb_valid);
    end
    checks++;
    if (wb_tag !== 6'd0 || wb_data !== 32'd0) begin
      errors++; $display("FAIL rst_head got=%0d/%h exp=0/0", wb_tag, wb_data);
    end
    checks++;
    if (count !== 3'd0 || err !== 1'b0) begin
      errors++; $display("FAIL rst_cnt_err got=%0d/%b exp=0/0", count, err);
    end
    do_reset();
  endtask

  task automatic test_single();
    tick(1, 6'd5, 0, 32'h4040_0000);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    checks++;
    if (wb_valid !== 1'b0 || issue_ok !== 1'b1) begin
      errors++; $display("FAIL t1_early got=%b/%b exp=0/1", wb_valid, issue_ok);
    end
    tick(0, 0, 0, 0);
    checks++;
    if (wb_valid !== 1'b1 || count !== 3'd1) begin
      errors++; $display("FAIL t1_valid got=%b/%0d exp=1/1", wb_valid, count);
    end
    checks++;
    if (wb_tag !== 6'd5 || wb_data !== 32'h4040_0000) begin
      errors++; $display("FAIL t1_head got=%0d/%h exp=5/40400000", wb_tag, wb_data);
    end
    tick(0, 0, 1, 0);
    checks++;
    if (wb_valid !== 1'b0 || count !== 3'd0) begin
      errors++; $display("FAIL t1_pop got=%b/%0d exp=0/0", wb_valid, count);
    end
  endtask

  task automatic test_fill_drain();
    for (int k = 1; k <= 4; k++) tick(1, 6'(k), 0, $urandom);
    checks++;
    if (issue_ok !== 1'b0) begin
      errors++; $display("FAIL t2_credit got=%b exp=0", issue_ok);
    end
    for (int k = 0; k < 3; k++) tick(0, 0, 0, 0);
    checks++;
    if (count !== 3'd4 || issue_ok !== 1'b0) begin
      errors++; $display("FAIL t2_full got=%0d/%b exp=4/0", count, issue_ok);
    end
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (wb_valid !== 1'b1 || wb_tag !== 6'(k)) begin
        errors++; $display("FAIL t2_order got=%b/%0d exp=1/%0d", wb_valid, wb_tag, k);
      end
      tick(0, 0, 1, 0);
      if (k == 1) begin
        checks++;
        if (issue_ok !== 1'b1 || count !== 3'd3) begin
          errors++; $display("FAIL t2_reopen got=%b/%0d exp=1/3", issue_ok, count);
        end
      end
    end
    checks++;
    if (wb_valid !== 1'b0 || count !== 3'd0 || err !== 1'b0) begin
      errors++; $display("FAIL t2_end got=%b/%0d/%b exp=0/0/0", wb_valid, count, err);
    end
  endtask

  task automatic test_push_pop();
    logic [5:0] exp_tags [4];
    exp_tags[0] = 6'd12; exp_tags[1] = 6'd13;
    exp_tags[2] = 6'd14; exp_tags[3] = 6'd0;
    for (int k = 10; k <= 13; k++) tick(1, 6'(k), 0, $urandom);
    for (int k = 0; k < 3; k++) tick(0, 0, 0, 0);
    tick(0, 0, 1, 0);
    checks++;
    if (issue_ok !== 1'b1 || count !== 3'd3) begin
      errors++; $display("FAIL t3_pop got=%b/%0d exp=1/3", issue_ok, count);
    end
    tick(1, 6'd14, 0, $urandom);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 1, 0);
    checks++;
    if (count !== 3'd3 || wb_tag !== 6'd12) begin
      errors++; $display("FAIL t3_same got=%0d/%0d exp=3/12", count, wb_tag);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (wb_tag !== exp_tags[k]) begin
        errors++; $display("FAIL t3_order got=%0d exp=%0d", wb_tag, exp_tags[k]);
      end
      tick(0, 0, 1, 0);
    end
    checks++;
    if (err !== 1'b0 || count !== 3'd0) begin
      errors++; $display("FAIL t3_end got=%b/%0d exp=0/0", err, count);
    end
  endtask

  task automatic test_overflow();
    logic [5:0] exp_tags [4];
    exp_tags[0] = 6'd21; exp_tags[1] = 6'd22;
    exp_tags[2] = 6'd23; exp_tags[3] = 6'd25;
    for (int k = 20; k <= 23; k++) tick(1, 6'(k), 0, $urandom);
    tick(1, 6'd24, 0, $urandom);
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL t4_err got=%b exp=1", err);
    end
    for (int k = 0; k < 3; k++) tick(0, 0, 0, 0);
    checks++;
    if (count !== 3'd4 || wb_tag !== 6'd20 || err !== 1'b1) begin
      errors++; $display("FAIL t4_drop got=%0d/%0d/%b exp=4/20/1", count, wb_tag, err);
    end
    tick(1, 6'd25, 0, $urandom);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 1, 0);
    checks++;
    if (count !== 3'd4 || wb_tag !== 6'd21) begin
      errors++; $display("FAIL t4_fullpp got=%0d/%0d exp=4/21", count, wb_tag);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (wb_tag !== exp_tags[k]) begin
        errors++; $display("FAIL t4_order got=%0d exp=%0d", wb_tag, exp_tags[k]);
      end
      tick(0, 0, 1, 0);
    end
    checks++;
    if (err !== 1'b1 || count !== 3'd0) begin
      errors++; $display("FAIL t4_sticky got=%b/%0d exp=1/0", err, count);
    end
  endtask

  task automatic test_not_ready();
    nready = 1'b1;
    tick(1, 6'd7, 0, 32'hdead_beef);
    nready = 1'b0;
    for (int k = 0; k < 3; k++) tick(0, 0, 0, 0);
    checks++;
    if (wb_valid !== 1'b1 || wb_tag !== 6'd7 || wb_data !== 32'hdead_beef) begin
      errors++; $display("FAIL t5_entry got=%b/%0d/%h exp=1/7/deadbeef", wb_valid, wb_tag, wb_data);
    end
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL t5_err got=%b exp=1", err);
    end
    tick(0, 0, 1, 0);
  endtask

  task automatic test_mid_reset();
    tick(1, 6'd30, 0, $urandom);
    tick(1, 6'd31, 0, $urandom);
    for (int k = 0; k < 3; k++) tick(0, 0, 0, 0);
    tick(1, 6'd32, 0, $urandom);
    tick(1, 6'd33, 0, $urandom);
    checks++;
    if (count !== 3'd2 || issue_ok !== 1'b0) begin
      errors++; $display("FAIL t6_pre got=%0d/%b exp=2/0", count, issue_ok);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if (wb_valid !== 1'b0 || count !== 3'd0 || issue_ok !== 1'b1) begin
      errors++; $display("FAIL t6_async got=%b/%0d/%b exp=0/0/1", wb_valid, count, issue_ok);
    end
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    rstn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick(0, 0, 0, 0);
      checks++;
      if (wb_valid !== 1'b0 || count !== 3'd0 || err !== 1'b0) begin
        errors++; $display("FAIL t6_ghost got=%b/%0d/%b exp=0/0/0", wb_valid, count, err);
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    bit en;
    for (int i = 0; i < 400; i++) begin
      ok     = (mq.size() + pend.size()) < DEP;
      en     = ok ? 1'($urandom) : ($urandom_range(0, 24) == 0);
      nready = ($urandom_range(0, 40) == 0);
      tick(en, 6'($urandom), 1'($urandom), $urandom);
      nready = 1'b0;
      checks++;
      if (count !== 3'(mq.size()) || wb_valid !== (mq.size() != 0)) begin
        errors++; $display("FAIL rnd_occ cyc=%0d got=%0d/%b exp=%0d", cyc, count, wb_valid, mq.size());
      end
      checks++;
      if (issue_ok !== ((mq.size() + pend.size()) < DEP) || err !== m_err) begin
        errors++; $display("FAIL rnd_ok_err cyc=%0d got=%b/%b exp=%b/%b", cyc, issue_ok, err,
                           (mq.size() + pend.size()) < DEP, m_err);
      end
      if (mq.size() != 0) begin
        checks++;
        if (wb_tag !== mq[0].tag || wb_data !== mq[0].data) begin
          errors++; $display("FAIL rnd_head cyc=%0d got=%0d/%h exp=%0d/%h", cyc, wb_tag, wb_data,
                             mq[0].tag, mq[0].data);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_drain();
    test_push_pop();
    test_overflow();
    do_reset();
    test_not_ready();
    do_reset();
    test_mid_reset();
    do_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
